mc_control: RTL and testbench
=============================

// Module: mc_control
// PURPOSE
// Multi-cycle successor to the single-cycle MIPS control decoder: same ISA subset, ALUFun encoding, PCSrc/RegDst/MemToReg codes.
// Sequences FETCH/DECODE/EXEC/MEM/WB over several cycles so one ALU and one memory port are shared.
// Memory latency is parametrised. IRQ is latched and taken only at an instruction boundary.
// Sits between the multi-cycle datapath (PC, IR, A/B/ALUOut/MDR regs) and the unified memory.
// PARAMETERS
// MEM_LAT  1   cycles per memory access (fetch, load, store); legal range 1..15
// IRQ_EN   1   0: IRQ input ignored, irq_pending held 0
// PORTS
// clk       in   1   clock, all state updates on rising edge
// reset     in   1   synchronous, active-high
// Instruct  in   32  IR contents, valid from DECODE onward
// IRQ       in   1   level interrupt request
// Kernel    in   1   PC[31]; 1 masks IRQ
// PCWr      out  1   PC write enable
// IRWr      out  1   IR write enable
// IorD      out  1   memory address: 0 = PC, 1 = ALUOut
// PCSrc     out  3   0 PC+4, 1 branch, 2 j-target, 3 rs, 4 IRQ vector, 5 exception vector
// RegDst    out  2   0 rd, 1 rt, 2 $ra, 3 $k0
// RegWr     out  1   register-file write enable
// ALUSrcA   out  2   0 PC, 1 A, 2 shamt
// ALUSrcB   out  2   0 B, 1 const 4, 2 ext imm, 3 ext imm<<2
// ALUFun    out  6   ALU function, same 6-bit encoding as the single-cycle decoder
// MemRd     out  1   memory read strobe
// MemWr     out  1   memory write strobe
// MemToReg  out  2   0 ALUOut, 1 MDR, 2 PC (return address)
// EXTOp     out  1   1 sign-extend, 0 zero-extend (andi only)
// LUOp      out  1   lui select
// State     out  3   current state code, debug/verification
// BEHAVIOUR
// - Moore outputs: decoded from state register, counter and Instruct only. Non-listed strobes are 0 in each state.
// - Reset: state=FETCH, cnt=0, irq_pending=0, cause=0. All write enables 0 during the reset cycle.
// - Reset mid-operation aborts immediately. A store in flight drops MemWr on the next edge.
// - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 BRJ=5 EXC=6.
// - FETCH: MemRd=1, IorD=0, ALU computes PC+4 (A=0, B=1, ALUFun=000000). cnt counts 0..MEM_LAT-1.
//   - At cnt==MEM_LAT-1: IRWr=1, PCWr=1, PCSrc=0, then go to DECODE, cnt=0.
//   - At cnt==0 with irq_pending=1: go to EXC instead (cause=IRQ), no memory read.
// - DECODE: ALU computes PC+(imm<<2) into ALUOut.
//   - Undefined opcode/funct goes to EXC (cause=UNDEF).
//   - Branch, j, jal, jr and jalr go to BRJ; all others go to EXEC.
// - EXEC: ALU operation, ALUFun/ALUSrc per instruction class.
//   - lw/sw go to MEM; all others go to WB.
// - MEM: IorD=1, MemRd (lw) or MemWr (sw) held for MEM_LAT cycles.
//   - lw then goes to WB; sw then goes to FETCH.
// - WB: RegWr=1, one cycle, then FETCH.
//   - R-type: RegDst=0, MemToReg=0. I-type: RegDst=1. lw: MemToReg=1.
// - BRJ: one cycle, then FETCH.
//   - Branch: PCWr = ALU cmp result (ALUFun is the compare code), PCSrc=1.
//   - j/jal: PCWr=1, PCSrc=2. jal also RegWr=1, RegDst=2, MemToReg=2.
//   - jr: PCSrc=3. jalr: PCSrc=3, RegWr=1, RegDst=0, MemToReg=2.
// - EXC: one cycle, then FETCH. PCWr=1, PCSrc=4 (IRQ) or 5 (UNDEF), RegWr=1, RegDst=3, MemToReg=2.
//   - irq_pending is cleared on EXC entry when cause=IRQ.
// - irq_pending: set on any edge where IRQ&&!Kernel&&IRQ_EN. It is a sticky latch; a short IRQ pulse is not lost.
// - Simultaneous: undefined detected in DECODE while irq_pending=1 takes UNDEF first. The pending IRQ stays latched and is masked by Kernel.
// - Latency: R/I = MEM_LAT+3; lw = 2*MEM_LAT+3; sw = 2*MEM_LAT+2; branch/jump = MEM_LAT+2; EXC = 1 (+ next fetch).
// - cnt is 4-bit and resets to 0 on every state change; it never wraps because the MEM_LAT range is checked.
// STRUCTURE
// - Shared package ctrl_pkg holds:
//   - opcode/funct constants and ALUFun codes;
//   - PCSrc/RegDst/MemToReg codes and the state enum;
//   - exception cause codes.
// - The single-cycle decoder imports the same package.
// - Sub-module ctrl_decode: combinational Instruct -> {class, ALUFun, ALUSrcA/B, EXTOp, LUOp, undefined}. mc_control holds only the FSM, counter and IRQ latch.
// TESTING
// - add $3,$1,$2 (0x00221820), MEM_LAT=1 -> states 0,1,2,4; RegWr=1 and RegDst=0 in cycle 4 only.
// - lw 0x8C220004 with MEM_LAT=3 -> MemRd high 3 cycles in FETCH and 3 in MEM; MemToReg=1 in WB; 9 cycles total.
// - beq taken/not-taken -> BRJ with ALUFun=110011; PCWr follows cmp; no RegWr.
// - Opcode 0x3F -> DECODE to EXC: PCSrc=5, RegDst=3, MemToReg=2, RegWr=1.
// - 1-cycle IRQ pulse during EXEC with Kernel=0 -> next FETCH cnt==0 enters EXC with PCSrc=4; pending cleared.
//   - Same pulse with Kernel=1: ignored.
// - reset during MEM of sw -> MemWr=0 next cycle; state=FETCH, irq_pending=0.

Source files
------------

// File: rtl/mc_control_pkg.sv
// Shared constants for the MIPS control path: opcode/funct values, ALUFun
// codes, datapath mux select codes, FSM state and exception cause encodings.
package mc_control_pkg;

  localparam logic [5:0] OP_R     = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_BLEZ = 6'h06,
                         OP_BGTZ  = 6'h07, OP_ADDI = 6'h08, OP_ADDIU= 6'h09,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2A;

  // [5:4] selects adder / logic / shifter / comparator
  localparam logic [5:0] ALU_ADD = 6'b000000, ALU_SUB = 6'b000001,
                         ALU_AND = 6'b011000, ALU_OR  = 6'b011110,
                         ALU_XOR = 6'b010110, ALU_NOR = 6'b010001,
                         ALU_SLL = 6'b100000, ALU_SRL = 6'b100001,
                         ALU_SRA = 6'b100011, ALU_EQ  = 6'b110011,
                         ALU_NEQ = 6'b110001, ALU_LT  = 6'b110101,
                         ALU_LEZ = 6'b111101, ALU_GTZ = 6'b111111;

  localparam logic [2:0] PC_INC = 3'd0, PC_BR = 3'd1, PC_JT = 3'd2,
                         PC_RS  = 3'd3, PC_IRQ = 3'd4, PC_EXC = 3'd5;
  localparam logic [1:0] RD_RD = 2'd0, RD_RT = 2'd1, RD_RA = 2'd2, RD_K0 = 2'd3;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;
  localparam logic [1:0] SA_PC = 2'd0, SA_A = 2'd1, SA_SH = 2'd2;
  localparam logic [1:0] SB_B = 2'd0, SB_4 = 2'd1, SB_IMM = 2'd2, SB_IMM2 = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_BRJ = 3'd5, S_EXC = 3'd6
  } state_t;

  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_IRQ, CAUSE_UNDEF} cause_t;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LW, CL_SW, CL_BR, CL_J, CL_JAL, CL_JR, CL_JALR
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [5:0] alufun;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       extop;
    logic       luop;
    logic       undef;
  } dec_t;

  // Instructions that finish in BRJ instead of EXEC/WB
  function automatic logic is_brj(iclass_t c);
    return c inside {CL_BR, CL_J, CL_JAL, CL_JR, CL_JALR};
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle controller (master) and datapath.
// Cmp is the ALU compare bit, used to qualify branch PC writes.
interface mc_control_if;
  import mc_control_pkg::*;
  logic [31:0] Instruct;
  logic        IRQ, Kernel, Cmp;
  logic        PCWr, IRWr, IorD, RegWr, MemRd, MemWr, EXTOp, LUOp;
  logic [2:0]  PCSrc, State;
  logic [1:0]  RegDst, ALUSrcA, ALUSrcB, MemToReg;
  logic [5:0]  ALUFun;

  modport master (
    input  Instruct, IRQ, Kernel, Cmp,
    output PCWr, IRWr, IorD, PCSrc, RegDst, RegWr, ALUSrcA, ALUSrcB, ALUFun,
           MemRd, MemWr, MemToReg, EXTOp, LUOp, State
  );
  modport slave (
    output Instruct, IRQ, Kernel, Cmp,
    input  PCWr, IRWr, IorD, PCSrc, RegDst, RegWr, ALUSrcA, ALUSrcB, ALUFun,
           MemRd, MemWr, MemToReg, EXTOp, LUOp, State
  );
endinterface

// File: rtl/mc_control_decode.sv
// Pure combinational instruction classifier: class, ALU setup and the
// undefined-instruction flag. No sequencing knowledge lives here.
module mc_control_decode
  import mc_control_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [5:0] op, fn;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_fields = ^instr[25:6];

  // opcode/funct -> class and EXEC-stage ALU configuration
  always_comb begin
    dec = '{cls: CL_I, alufun: ALU_ADD, srca: SA_A, srcb: SB_IMM,
            extop: 1'b1, luop: 1'b0, undef: 1'b0};
    case (op)
      OP_R: begin
        dec.cls  = CL_R;
        dec.srcb = SB_B;
        case (fn)
          FN_ADD, FN_ADDU: dec.alufun = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alufun = ALU_SUB;
          FN_AND:  dec.alufun = ALU_AND;
          FN_OR:   dec.alufun = ALU_OR;
          FN_XOR:  dec.alufun = ALU_XOR;
          FN_NOR:  dec.alufun = ALU_NOR;
          FN_SLT:  dec.alufun = ALU_LT;
          FN_SLL:  begin dec.alufun = ALU_SLL; dec.srca = SA_SH; end
          FN_SRL:  begin dec.alufun = ALU_SRL; dec.srca = SA_SH; end
          FN_SRA:  begin dec.alufun = ALU_SRA; dec.srca = SA_SH; end
          FN_JR:   dec.cls = CL_JR;
          FN_JALR: dec.cls = CL_JALR;
          default: dec.undef = 1'b1;
        endcase
      end
      OP_J:    dec.cls = CL_J;
      OP_JAL:  dec.cls = CL_JAL;
      OP_BEQ:  begin dec.cls = CL_BR; dec.srcb = SB_B; dec.alufun = ALU_EQ;  end
      OP_BNE:  begin dec.cls = CL_BR; dec.srcb = SB_B; dec.alufun = ALU_NEQ; end
      OP_BLEZ: begin dec.cls = CL_BR; dec.srcb = SB_B; dec.alufun = ALU_LEZ; end
      OP_BGTZ: begin dec.cls = CL_BR; dec.srcb = SB_B; dec.alufun = ALU_GTZ; end
      OP_ADDI, OP_ADDIU: dec.alufun = ALU_ADD;
      OP_SLTI: dec.alufun = ALU_LT;
      OP_ANDI: begin dec.alufun = ALU_AND; dec.extop = 1'b0; end
      OP_LUI:  dec.luop = 1'b1;
      OP_LW:   dec.cls = CL_LW;
      OP_SW:   dec.cls = CL_SW;
      default: dec.undef = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS controller: FSM, memory-latency counter and IRQ latch.
// Instruction classification comes from mc_control_decode.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter bit IRQ_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);
  // out-of-range latencies are clamped so the 4-bit counter cannot wrap
  localparam int         LAT_C    = (MEM_LAT < 1) ? 1 : (MEM_LAT > 15) ? 15 : MEM_LAT;
  localparam logic [3:0] CNT_LAST = 4'(LAT_C - 1);

  state_t     state, state_nx;
  cause_t     cause, cause_nx;
  logic [3:0] cnt;
  logic       irq_pending, irq_set, irq_clr, take_irq, cnt_last;
  dec_t       dec;

  logic       pcwr, irwr, iord, regwr, memrd, memwr, extop, luop;
  logic [2:0] pcsrc;
  logic [1:0] regdst, srca, srcb, m2r;
  logic [5:0] alufun;

  mc_control_decode u_dec (.instr(bus.Instruct), .dec(dec));

  // Kernel is PC[31], a registered datapath bit, so using it here keeps
  // the outputs a function of registered state
  assign take_irq = irq_pending & ~bus.Kernel;
  assign cnt_last = (cnt == CNT_LAST);
  assign irq_set  = IRQ_EN & bus.IRQ & ~bus.Kernel;
  assign irq_clr  = (state == S_FETCH) && (state_nx == S_EXC);

  // next-state: IRQ only at an instruction boundary, UNDEF wins in DECODE
  always_comb begin
    state_nx = state;
    cause_nx = cause;
    case (state)
      S_FETCH:
        if (cnt == 4'd0 && take_irq) begin
          state_nx = S_EXC;
          cause_nx = CAUSE_IRQ;
        end else if (cnt_last) state_nx = S_DECODE;
      S_DECODE:
        if (dec.undef) begin
          state_nx = S_EXC;
          cause_nx = CAUSE_UNDEF;
        end else if (is_brj(dec.cls)) state_nx = S_BRJ;
        else state_nx = S_EXEC;
      S_EXEC:
        state_nx = (dec.cls == CL_LW || dec.cls == CL_SW) ? S_MEM : S_WB;
      S_MEM:
        if (cnt_last) state_nx = (dec.cls == CL_LW) ? S_WB : S_FETCH;
      default: state_nx = S_FETCH;
    endcase
  end

  // state, counter (cleared on every state change) and sticky IRQ latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      cause       <= CAUSE_NONE;
      cnt         <= 4'd0;
      irq_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      cause       <= cause_nx;
      cnt         <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
      irq_pending <= (irq_pending & ~irq_clr) | irq_set;
    end
  end

  // per-state datapath controls; ALU setup follows the decoder by default
  always_comb begin
    pcwr = 1'b0; irwr = 1'b0; iord = 1'b0; regwr = 1'b0;
    memrd = 1'b0; memwr = 1'b0;
    pcsrc = PC_INC; regdst = RD_RD; m2r = M2R_ALU;
    srca = dec.srca; srcb = dec.srcb; alufun = dec.alufun;
    extop = dec.extop; luop = dec.luop;
    case (state)
      S_FETCH: begin
        srca = SA_PC; srcb = SB_4; alufun = ALU_ADD; extop = 1'b1; luop = 1'b0;
        if (!(cnt == 4'd0 && take_irq)) begin
          memrd = 1'b1;
          if (cnt_last) begin irwr = 1'b1; pcwr = 1'b1; end
        end
      end
      S_DECODE: begin
        srca = SA_PC; srcb = SB_IMM2; alufun = ALU_ADD; extop = 1'b1; luop = 1'b0;
      end
      S_MEM: begin
        iord  = 1'b1;
        memrd = (dec.cls == CL_LW);
        memwr = (dec.cls == CL_SW);
      end
      S_WB: begin
        regwr  = 1'b1;
        regdst = (dec.cls == CL_R) ? RD_RD : RD_RT;
        m2r    = (dec.cls == CL_LW) ? M2R_MDR : M2R_ALU;
      end
      S_BRJ:
        case (dec.cls)
          CL_BR:   begin pcwr = bus.Cmp; pcsrc = PC_BR; end
          CL_J:    begin pcwr = 1'b1; pcsrc = PC_JT; end
          CL_JAL:  begin pcwr = 1'b1; pcsrc = PC_JT; regwr = 1'b1; regdst = RD_RA; m2r = M2R_PC; end
          CL_JR:   begin pcwr = 1'b1; pcsrc = PC_RS; end
          CL_JALR: begin pcwr = 1'b1; pcsrc = PC_RS; regwr = 1'b1; regdst = RD_RD; m2r = M2R_PC; end
          default: ;
        endcase
      S_EXC: begin
        pcwr   = 1'b1;
        pcsrc  = (cause == CAUSE_IRQ) ? PC_IRQ : PC_EXC;
        regwr  = 1'b1;
        regdst = RD_K0;
        m2r    = M2R_PC;
      end
      default: ;
    endcase
  end

  // write enables are held low while reset is asserted
  assign bus.PCWr     = pcwr  & ~reset;
  assign bus.IRWr     = irwr  & ~reset;
  assign bus.RegWr    = regwr & ~reset;
  assign bus.MemWr    = memwr & ~reset;
  assign bus.MemRd    = memrd;
  assign bus.IorD     = iord;
  assign bus.PCSrc    = pcsrc;
  assign bus.RegDst   = regdst;
  assign bus.MemToReg = m2r;
  assign bus.ALUSrcA  = srca;
  assign bus.ALUSrcB  = srcb;
  assign bus.ALUFun   = alufun;
  assign bus.EXTOp    = extop;
  assign bus.LUOp     = luop;
  assign bus.State    = state;
endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle vector table on a MEM_LAT=1
// instance, plus hand sequences for lw at MEM_LAT=3, IRQ and reset cases.
module tb_mc_control;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_control_if if1 ();
  mc_control_if if3 ();

  mc_control #(.MEM_LAT(1), .IRQ_EN(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.master));
  mc_control #(.MEM_LAT(3), .IRQ_EN(1'b1)) u3 (.clk(clk), .reset(reset), .bus(if3.master));

  localparam logic [31:0] I_ADD  = 32'h00221820, I_OR   = 32'h00221825,
                          I_SLL  = 32'h00021080, I_BEQ  = 32'h10220003,
                          I_SW   = 32'hAC220004, I_LW   = 32'h8C220004,
                          I_J    = 32'h08000010, I_JAL  = 32'h0C000010,
                          I_JR   = 32'h03E00008, I_JALR = 32'h0020F809,
                          I_UND  = 32'hFC000000, I_ADDI = 32'h20220005;

  int checks = 0, failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic        cmp;
    logic [2:0]  st;
    logic [5:0]  strb;   // {PCWr, IRWr, MemRd, MemWr, RegWr, IorD}
    logic [2:0]  pcsrc;
    logic [1:0]  regdst;
    logic [1:0]  m2r;
    int          alu;    // -1: ALUFun not checked
  } vec_t;

  vec_t tbl[$];

  logic [2:0] lw_st [10];
  logic       lw_mrd[10], lw_irw[10], lw_rw[10], lw_io[10];
  logic [1:0] lw_m2r[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [31:0] i, logic c, logic [2:0] st, logic [5:0] s,
                              logic [2:0] ps, logic [1:0] rd, logic [1:0] mr, int alu);
    vec_t v;
    v.instr = i; v.cmp = c; v.st = st; v.strb = s;
    v.pcsrc = ps; v.regdst = rd; v.m2r = mr; v.alu = alu;
    return v;
  endfunction

  // FETCH and DECODE look the same for every instruction at MEM_LAT=1
  task automatic fd(input logic [31:0] i, input logic c);
    tbl.push_back(mk(i, c, 3'd0, 6'b111000, 3'd0, 2'd0, 2'd0, 'h00));
    tbl.push_back(mk(i, c, 3'd1, 6'b000000, 3'd0, 2'd0, 2'd0, 'h00));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if1.IRQ = 1'b0; if1.Kernel = 1'b0; if1.Cmp = 1'b0; if1.Instruct = I_ADD;
    if3.IRQ = 1'b0; if3.Kernel = 1'b0; if3.Cmp = 1'b0; if3.Instruct = I_ADD;
    @(negedge clk); @(negedge clk); #1;
    chk("reset u1", {if1.State, if1.PCWr, if1.IRWr, if1.RegWr, if1.MemWr}, 32'h0);
    chk("reset u3", {if3.State, if3.PCWr, if3.IRWr, if3.RegWr, if3.MemWr}, 32'h0);
    reset = 1'b0;
  endtask

  task automatic chk1(input string name, input logic [2:0] st, input logic [5:0] s,
                      input logic [2:0] ps);
    chk(name, {if1.State, if1.PCWr, if1.IRWr, if1.MemRd, if1.MemWr, if1.RegWr, if1.IorD, if1.PCSrc},
        {st, s, ps});
  endtask

  initial begin
    // ---- vector table, MEM_LAT=1 ----
    fd(I_ADD, 0);
    tbl.push_back(mk(I_ADD, 0, 3'd2, 6'b000000, 3'd0, 2'd0, 2'd0, 'h00));
    tbl.push_back(mk(I_ADD, 0, 3'd4, 6'b000010, 3'd0, 2'd0, 2'd0, -1));
    fd(I_BEQ, 1);
    tbl.push_back(mk(I_BEQ, 1, 3'd5, 6'b100000, 3'd1, 2'd0, 2'd0, 'h33));
    fd(I_BEQ, 0);
    tbl.push_back(mk(I_BEQ, 0, 3'd5, 6'b000000, 3'd1, 2'd0, 2'd0, 'h33));
    fd(I_SW, 0);
    tbl.push_back(mk(I_SW, 0, 3'd2, 6'b000000, 3'd0, 2'd0, 2'd0, 'h00));
    tbl.push_back(mk(I_SW, 0, 3'd3, 6'b000101, 3'd0, 2'd0, 2'd0, -1));
    fd(I_J, 0);
    tbl.push_back(mk(I_J, 0, 3'd5, 6'b100000, 3'd2, 2'd0, 2'd0, -1));
    fd(I_JAL, 0);
    tbl.push_back(mk(I_JAL, 0, 3'd5, 6'b100010, 3'd2, 2'd2, 2'd2, -1));
    fd(I_JR, 0);
    tbl.push_back(mk(I_JR, 0, 3'd5, 6'b100000, 3'd3, 2'd0, 2'd0, -1));
    fd(I_JALR, 0);
    tbl.push_back(mk(I_JALR, 0, 3'd5, 6'b100010, 3'd3, 2'd0, 2'd2, -1));
    fd(I_UND, 0);
    tbl.push_back(mk(I_UND, 0, 3'd6, 6'b100010, 3'd5, 2'd3, 2'd2, -1));
    fd(I_ADDI, 0);
    tbl.push_back(mk(I_ADDI, 0, 3'd2, 6'b000000, 3'd0, 2'd0, 2'd0, 'h00));
    tbl.push_back(mk(I_ADDI, 0, 3'd4, 6'b000010, 3'd0, 2'd1, 2'd0, -1));
    fd(I_OR, 0);
    tbl.push_back(mk(I_OR, 0, 3'd2, 6'b000000, 3'd0, 2'd0, 2'd0, 'h1E));
    tbl.push_back(mk(I_OR, 0, 3'd4, 6'b000010, 3'd0, 2'd0, 2'd0, -1));
    fd(I_SLL, 0);
    tbl.push_back(mk(I_SLL, 0, 3'd2, 6'b000000, 3'd0, 2'd0, 2'd0, 'h20));
    tbl.push_back(mk(I_SLL, 0, 3'd4, 6'b000010, 3'd0, 2'd0, 2'd0, -1));
    tbl.push_back(mk(I_ADD, 0, 3'd0, 6'b111000, 3'd0, 2'd0, 2'd0, 'h00));

    lw_st  = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    lw_mrd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    lw_irw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    lw_rw  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    lw_io  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    lw_m2r = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};

    do_reset();
    foreach (tbl[k]) begin
      if1.Instruct = tbl[k].instr;
      if1.Cmp      = tbl[k].cmp;
      #1;
      chk($sformatf("vec%0d", k),
          {if1.State, if1.PCWr, if1.IRWr, if1.MemRd, if1.MemWr, if1.RegWr, if1.IorD,
           if1.PCSrc, if1.RegDst, if1.MemToReg},
          {tbl[k].st, tbl[k].strb, tbl[k].pcsrc, tbl[k].regdst, tbl[k].m2r});
      if (tbl[k].alu >= 0) chk($sformatf("vec%0d alu", k), {26'd0, if1.ALUFun}, tbl[k].alu);
      @(negedge clk);
    end

    // ---- lw at MEM_LAT=3: 9 cycles, then next FETCH ----
    do_reset();
    if3.Instruct = I_LW;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("lw c%0d", c),
          {if3.State, if3.MemRd, if3.IRWr, if3.RegWr, if3.IorD, if3.MemToReg},
          {lw_st[c], lw_mrd[c], lw_irw[c], lw_rw[c], lw_io[c], lw_m2r[c]});
      @(negedge clk);
    end

    // ---- IRQ pulse in EXEC, Kernel=0: taken at next FETCH ----
    do_reset();
    repeat (2) @(negedge clk);
    if1.IRQ = 1'b1;                       // EXEC
    @(negedge clk); if1.IRQ = 1'b0;       // WB
    @(negedge clk); #1;
    chk1("irq fetch", 3'd0, 6'b000000, 3'd0);
    @(negedge clk); #1;
    chk1("irq exc", 3'd6, 6'b100010, 3'd4);
    chk("irq exc dst", {if1.RegDst, if1.MemToReg}, {2'd3, 2'd2});
    @(negedge clk); #1;
    chk1("irq cleared", 3'd0, 6'b111000, 3'd0);
    @(negedge clk); #1;
    chk("irq decode", {29'd0, if1.State}, 32'd1);

    // ---- same pulse with Kernel=1: ignored ----
    do_reset();
    repeat (2) @(negedge clk);
    if1.IRQ = 1'b1; if1.Kernel = 1'b1;
    @(negedge clk); if1.IRQ = 1'b0; if1.Kernel = 1'b0;
    @(negedge clk); #1;
    chk1("kmask fetch", 3'd0, 6'b111000, 3'd0);
    @(negedge clk); #1;
    chk("kmask decode", {29'd0, if1.State}, 32'd1);

    // ---- UNDEF with IRQ pending: UNDEF first, IRQ kept until Kernel drops ----
    do_reset();
    if1.Instruct = I_UND; if1.IRQ = 1'b1;  // FETCH, pulse latches at this edge
    @(negedge clk); if1.IRQ = 1'b0;        // DECODE
    @(negedge clk); if1.Kernel = 1'b1; #1; // EXC
    chk1("simul undef", 3'd6, 6'b100010, 3'd5);
    @(negedge clk); if1.Instruct = I_ADD; #1;
    chk1("simul masked", 3'd0, 6'b111000, 3'd0);
    @(negedge clk);                        // DECODE
    @(negedge clk); if1.Kernel = 1'b0;     // EXEC
    @(negedge clk);                        // WB
    @(negedge clk); #1;
    chk1("simul irq fetch", 3'd0, 6'b000000, 3'd0);
    @(negedge clk); #1;
    chk1("simul irq exc", 3'd6, 6'b100010, 3'd4);

    // ---- reset during MEM of sw, with an IRQ latched beforehand ----
    do_reset();
    if1.Instruct = I_SW;
    repeat (2) @(negedge clk);
    if1.IRQ = 1'b1;                        // EXEC
    @(negedge clk); if1.IRQ = 1'b0; #1;    // MEM
    chk1("sw mem", 3'd3, 6'b000101, 3'd0);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst sw memwr", {29'd0, if1.State, if1.MemWr}, 32'd0);
    reset = 1'b0; #1;
    chk1("rst fetch", 3'd0, 6'b111000, 3'd0);
    @(negedge clk); #1;
    chk("rst decode", {29'd0, if1.State}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
